// File: rtl/adder_operand_stager_if.sv
// Bus bundle between a producer/consumer and the adder operand stager.
// The slave modport is the stager side; the master modport is the environment side.
interface adder_operand_stager_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] sum_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [LW-1:0]    level;
  logic [7:0]       drop_cnt;

  modport slave (
    input  clr, in_valid, in_a, in_b, sum_in, res_ready,
    output in_ready, a_out, b_out, res_valid, res_data, level, drop_cnt
  );

  modport master (
    output clr, in_valid, in_a, in_b, sum_in, res_ready,
    input  in_ready, a_out, b_out, res_valid, res_data, level, drop_cnt
  );
endinterface

// File: rtl/adder_operand_stager.sv
// Operand FIFO feeding an external combinational adder plus a registered result slot.
// Optional rejected-push counter enabled by defining ADDER_STAGER_DROP_CNT_EN.
module adder_operand_stager #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  adder_operand_stager_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               in_ready_s, push_s, pop_s;
  logic [2*WIDTH-1:0] head_s;

  // Handshake decode; in_ready looks only at the registered level so a full FIFO never accepts.
  always_comb begin
    in_ready_s = (level_q != FULL_LVL);
    push_s     = bus.in_valid & in_ready_s & ~bus.clr;
    pop_s      = (level_q != {LW{1'b0}}) & (~res_valid_q | bus.res_ready) & ~bus.clr;
    if (level_q != {LW{1'b0}}) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = {(2*WIDTH){1'b0}};
    end
  end

  // Next-state for pointers, occupancy and result slot; clr dominates push/pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (bus.clr) begin
      wr_ptr_d    = {PW{1'b0}};
      rd_ptr_d    = {PW{1'b0}};
      level_d     = {LW{1'b0}};
      res_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        res_valid_d = 1'b1;
        res_data_d  = bus.sum_in;
      end else if (res_valid_q & bus.res_ready) begin
        res_valid_d = 1'b0;
      end else begin
        res_valid_d = res_valid_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Control and result state registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      level_q     <= {LW{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Operand storage; contents are don't-care until written, so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
    end
  end

`ifdef ADDER_STAGER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of cycles where an offered pair was refused.
  always_comb begin
    if (bus.in_valid & ~in_ready_s & (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.a_out     = head_s[2*WIDTH-1:WIDTH];
  assign bus.b_out     = head_s[WIDTH-1:0];
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_adder_operand_stager.sv
// Directed scoreboard bench for adder_operand_stager with a behavioural adder on sum_in.
module tb_adder_operand_stager;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   rej = 0;
  logic [7:0] exp_q [$];

  adder_operand_stager_if #(.WIDTH(8), .DEPTH(4)) ifc ();

  adder_operand_stager #(.WIDTH(8), .DEPTH(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (ifc.slave)
  );

  always #5 clk = ~clk;

  assign ifc.sum_in = ifc.a_out + ifc.b_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop();
`ifdef ADDER_STAGER_DROP_CNT_EN
    return (rej > 255) ? 32'd255 : 32'(rej);
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit accept);
    logic [7:0] s;
    ifc.in_valid = 1'b1;
    ifc.in_a     = a;
    ifc.in_b     = b;
    s = a + b;
    if (accept) exp_q.push_back(s);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || ifc.res_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 50), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: a result consumed at the coming edge must match the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && ifc.res_valid && ifc.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL result_unexpected observed %0h expected none", ifc.res_data);
      end else begin
        chk("result", 32'(ifc.res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ifc.clr = 1'b0; ifc.in_valid = 1'b0; ifc.in_a = 8'h00; ifc.in_b = 8'h00; ifc.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_data", 32'(ifc.res_data), 32'd0);
    chk("rst_level", 32'(ifc.level), 32'd0);
    chk("rst_a_out", 32'(ifc.a_out), 32'd0);
    chk("rst_b_out", 32'(ifc.b_out), 32'd0);
    chk("rst_drop", 32'(ifc.drop_cnt), 32'd0);

    // Latency of a single pair
    @(posedge clk); #1;
    ifc.res_ready = 1'b1;
    push(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    chk("lat_a_out", 32'(ifc.a_out), 32'h12);
    chk("lat_b_out", 32'(ifc.b_out), 32'h34);
    chk("lat_level1", 32'(ifc.level), 32'd1);
    @(negedge clk);
    chk("lat_res_valid", 32'(ifc.res_valid), 32'd1);
    chk("lat_res_data", 32'(ifc.res_data), 32'h46);
    chk("lat_level0", 32'(ifc.level), 32'd0);
    @(negedge clk);
    chk("lat_res_consumed", 32'(ifc.res_valid), 32'd0);

    // Backpressure: fill to DEPTH, sixth pair refused
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk("bp_in_ready", 32'(ifc.in_ready), (i <= 5) ? 32'd1 : 32'd0);
      if (i == 6) chk("bp_level_full", 32'(ifc.level), 32'd4);
      push(8'(i), 8'(i), i <= 5);
      if (i == 6) rej++;
    end
    chk("bp_res_valid", 32'(ifc.res_valid), 32'd1);
    chk("bp_first_res", 32'(ifc.res_data), 32'h02);
    chk("bp_level", 32'(ifc.level), 32'd4);
    chk("bp_drop", 32'(ifc.drop_cnt), exp_drop());
    ifc.res_ready = 1'b1;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("bp_back_to_back_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_res_idle", 32'(ifc.res_valid), 32'd0);

    // Carry-out discarded, then pointer wrap at full throughput
    @(posedge clk); #1;
    push(8'hFF, 8'h01, 1'b1);
    push(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push(8'($urandom), 8'($urandom), 1'b1);
      chk("tput_level", 32'(ifc.level), 32'd1);
    end
    wait_drain();

    // Full with simultaneous pop: push refused, level 4 -> 3
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 8'h20, 1'b1);
    chk("fp_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("fp_level4", 32'(ifc.level), 32'd4);
    ifc.res_ready = 1'b1;
    ifc.in_valid = 1'b1; ifc.in_a = 8'h99; ifc.in_b = 8'h99;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.res_ready = 1'b0;
    rej++;
    chk("fp_level3", 32'(ifc.level), 32'd3);
    chk("fp_drop", 32'(ifc.drop_cnt), exp_drop());

    // Long rejection run to saturate the drop counter
    push(8'h07, 8'h07, 1'b1);
    ifc.in_valid = 1'b1; ifc.in_a = 8'h55; ifc.in_b = 8'h55;
    repeat (300) @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    rej += 300;
    chk("sat_drop", 32'(ifc.drop_cnt), exp_drop());
    ifc.res_ready = 1'b1;
    wait_drain();

    // clr with 3 queued pairs and a pending result
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h30, 8'(i), 1'b1);
    chk("clr_pre_level", 32'(ifc.level), 32'd3);
    chk("clr_pre_valid", 32'(ifc.res_valid), 32'd1);
    ifc.clr = 1'b1;
    ifc.in_valid = 1'b1; ifc.in_a = 8'h44; ifc.in_b = 8'h44;
    @(posedge clk); #1;
    ifc.clr = 1'b0;
    ifc.in_valid = 1'b0;
    exp_q.delete();
    chk("clr_level", 32'(ifc.level), 32'd0);
    chk("clr_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("clr_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("clr_a_out", 32'(ifc.a_out), 32'd0);
    chk("clr_drop_kept", 32'(ifc.drop_cnt), exp_drop());

    // Asynchronous reset mid-burst
    ifc.res_ready = 1'b1;
    push(8'h01, 8'h02, 1'b1);
    push(8'h03, 8'h04, 1'b1);
    ifc.in_valid = 1'b1; ifc.in_a = 8'h05; ifc.in_b = 8'h06;
    #2 rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    exp_q.delete();
    rej = 0;
    #1;
    chk("arst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("arst_res_data", 32'(ifc.res_data), 32'd0);
    chk("arst_level", 32'(ifc.level), 32'd0);
    chk("arst_a_out", 32'(ifc.a_out), 32'd0);
    chk("arst_b_out", 32'(ifc.b_out), 32'd0);
    chk("arst_drop", 32'(ifc.drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    push(8'h21, 8'h22, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_operand_stager.md
Name: adder_operand_stager

Overview:
- Upstream/downstream companion of the 8-bit combinational adder macro in the user project area.
- Buffers operand pairs (A,B) in a small FIFO and presents the FIFO head to the adder's a_in/b_in.
- Captures the adder's sum into a registered result port with a valid/ready handshake.
- Lets a bursty producer (io pads or logic analyser) drive the adder and receive one registered result per pair.

Parameters:
- WIDTH, 8, operand and sum width; must match the adder macro.
- DEPTH, 4, FIFO depth in operand pairs; power of two, at least 2.

Ports:
- wb_clk_i  input  1  single clock for all state.
- wb_rst_i  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; empties FIFO and drops the pending result.
- in_valid  input  1  producer presents a pair.
- in_ready  output  1  stager accepts a pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- a_out  output  WIDTH  to adder a_in; FIFO head A.
- b_out  output  WIDTH  to adder b_in; FIFO head B.
- sum_in  input  WIDTH  from adder sum; combinational function of a_out/b_out.
- res_valid  output  1  result register holds an unconsumed sum.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  registered sum.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- drop_cnt  output  8  rejected-push counter; see Optional Feature.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - read/write pointers and level cleared to 0.
  - res_valid=0, res_data=0, drop_cnt=0.
  - FIFO storage need not be cleared.
  - a_out/b_out read 0 while the FIFO is empty.
- in_ready = (level != DEPTH).
  - Depends only on registered level, never on same-cycle pop.
  - A push offered while full is rejected even if a pop happens that cycle.
- push = in_valid & in_ready.
  - Writes {in_a,in_b} at wr_ptr; wr_ptr increments modulo DEPTH and wraps naturally.
- Head outputs: a_out/b_out = storage[rd_ptr] when level>0, else 0. No extra register; the adder sees the head immediately.
- pop = (level>0) & (~res_valid | res_ready).
  - On pop: res_data<=sum_in, res_valid<=1, rd_ptr increments modulo DEPTH.
- If res_valid & res_ready & no pop (FIFO empty): res_valid<=0; res_data holds its last value.
- level update: +1 on push only; -1 on pop only; unchanged on push and pop together.
- Latency: a pair pushed in cycle N into an empty stager with an empty result register is on a_out/b_out in N+1 and on res_data with res_valid=1 in N+2.
- Throughput: one result per cycle when res_ready is held high and pushes are continuous.
- Arithmetic: none internal. res_data is sum_in verbatim. The stager never widens or carries.
- clr (synchronous, lower priority than reset, higher than push/pop):
  - pointers and level to 0, res_valid<=0.
  - A same-cycle push is discarded.
  - drop_cnt is not cleared.
- Reset asserted mid-burst: all in-flight pairs and the pending result are lost. in_ready rises in the first cycle after reset release.
- No state machine beyond the FIFO and result register. Result-register states are EMPTY (res_valid=0) and FULL (res_valid=1), with the transitions above.

Optional Feature:
- Macro: ADDER_STAGER_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 each cycle with in_valid=1 and in_ready=0; saturates at 255; cleared only by reset.
- Undefined: drop_cnt tied to 0, no counter flops. All other behaviour is identical.

Test Plan:
- Reset then idle -> in_ready=1, res_valid=0, res_data=0, level=0, a_out=b_out=0.
- Push (A=0x12,B=0x34) in cycle N, res_ready=1, adder model -> a_out=0x12 in N+1; res_data=0x46, res_valid=1 in N+2; level back to 0.
- res_ready=0; push 5 pairs (0x01+0x01 .. 0x05+0x05) with DEPTH=4:
  - first result 0x02 is captured;
  - level reaches 4 and in_ready=0;
  - the 6th offered pair is rejected;
  - then release res_ready -> results 0x02,0x04,0x06,0x08,0x0A in order, one per cycle.
- Wrap and overflow: push 0xFF+0x01 and 0x80+0x80 -> res_data 0x00 then 0x00. Run 10 pairs through to exercise pointer wrap -> in-order results.
- Full with simultaneous pop and push offered -> push rejected, level goes 4->3. With macro defined, drop_cnt increments by 1 per rejected cycle and saturates at 255 after 300 rejected cycles.
- clr with 3 queued pairs and res_valid=1 -> next cycle level=0, res_valid=0, in_ready=1. Asserting wb_rst_i low mid-burst -> all outputs at reset values immediately, without a clock edge.
